bank_read_streamer: RTL

//  Downstream read master for the 128x128 dual-port SRAM bank. Accepts a burst request
//  (start address, length) and drives the bank read port (chip select + address).

---
 rtl/bank_read_streamer_if.sv | 30 +++
 rtl/bank_read_streamer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bank_read_streamer_if.sv
// Bundles the request channel, the SRAM read port and the output stream of the
// bank read streamer. The streamer uses the slave view; its environment
// (requester, bank, downstream sink) uses the master view.
interface bank_read_streamer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              bank_cs;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_len, bank_data, out_ready,
    input  req_ready, bank_cs, bank_addr, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, bank_data, out_ready,
    output req_ready, bank_cs, bank_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bank_read_streamer.sv
// Burst read master for the 128x128 SRAM bank. Issues one chip select per line,
// absorbs the fixed read latency in a shift pipe and buffers returned lines in a
// small FIFO. Reads are only issued when a FIFO slot is guaranteed, so
// backpressure never drops data.
module bank_read_streamer #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic vsi_clk,
  input  logic vsi_reset,
  bank_read_streamer_if.slave bus
);
  localparam int FIFO_D = RD_LAT + 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = $clog2(FIFO_D + RD_LAT + 1) + 1;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT             state_r;
  logic [ADDR_W-1:0] addrQ_r;
  logic [LEN_W-1:0]  issueCnt_r;
  logic [LEN_W-1:0]  beatCnt_r;
  logic              reqReady_r;
  logic              busy_r;
  logic [RD_LAT-1:0] csPipe_r;
  logic [RD_LAT-1:0] lastPipe_r;
  logic [DATA_W-1:0] fifoMem_r [FIFO_D];
  logic [FIFO_D-1:0] fifoLast_r;
  logic [PTR_W-1:0]  wrPtr_r;
  logic [PTR_W-1:0]  rdPtr_r;
  logic [CNT_W-1:0]  fifoCnt_r;

  logic              fifoNotEmpty_s;
  logic              pop_s;
  logic              push_s;
  logic              pushLast_s;
  logic              issue_s;
  logic              issueLast_s;
  logic              accept_s;
  logic [CNT_W-1:0]  inFlight_s;
  logic [CNT_W-1:0]  credit_s;
  logic [LEN_W-1:0]  reqLenFull_s;

  function automatic logic [CNT_W-1:0] countOnes(input logic [RD_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Issue decision: a read goes out only if its line is certain to find a FIFO slot
  always_comb begin
    fifoNotEmpty_s = (fifoCnt_r != {CNT_W{1'b0}});
    pop_s          = fifoNotEmpty_s && bus.out_ready;
    push_s         = csPipe_r[RD_LAT-1];
    pushLast_s     = lastPipe_r[RD_LAT-1];
    inFlight_s     = countOnes(csPipe_r);
    credit_s       = fifoCnt_r + inFlight_s - {{(CNT_W-1){1'b0}}, pop_s};
    issue_s        = (state_r == RUN) && (issueCnt_r != {LEN_W{1'b0}}) &&
                     (credit_s < CNT_W'(FIFO_D));
    issueLast_s    = (issueCnt_r == LEN_W'(1));
    accept_s       = bus.req_valid && reqReady_r;
    if (bus.req_len == {ADDR_W{1'b0}}) begin
      reqLenFull_s = LEN_W'(2 ** ADDR_W);
    end else begin
      reqLenFull_s = {1'b0, bus.req_len};
    end
  end

  // Burst control FSM: accept, issue addresses, count beats out, return to idle
  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      state_r    <= IDLE;
      addrQ_r    <= {ADDR_W{1'b0}};
      issueCnt_r <= {LEN_W{1'b0}};
      beatCnt_r  <= {LEN_W{1'b0}};
      reqReady_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= RUN;
            addrQ_r    <= bus.req_addr;
            issueCnt_r <= reqLenFull_s;
            beatCnt_r  <= reqLenFull_s;
            reqReady_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (issue_s) begin
            addrQ_r    <= addrQ_r + ADDR_W'(1);
            issueCnt_r <= issueCnt_r - LEN_W'(1);
          end
          if (pop_s) begin
            beatCnt_r <= beatCnt_r - LEN_W'(1);
          end
          if (pop_s && (beatCnt_r == LEN_W'(1))) begin
            state_r    <= IDLE;
            reqReady_r <= 1'b1;
            busy_r     <= 1'b0;
          end else if ((state_r == RUN) && (issueCnt_r == {LEN_W{1'b0}})) begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r    <= IDLE;
          reqReady_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency pipe: marks which cycles carry valid bank data and which is the last line
  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      csPipe_r   <= {RD_LAT{1'b0}};
      lastPipe_r <= {RD_LAT{1'b0}};
    end else begin
      csPipe_r[0]   <= issue_s;
      lastPipe_r[0] <= issue_s && issueLast_s;
      for (int i = 1; i < RD_LAT; i++) begin
        csPipe_r[i]   <= csPipe_r[i-1];
        lastPipe_r[i] <= lastPipe_r[i-1];
      end
    end
  end

  // Output FIFO: capture returning lines, advance the head on each accepted beat
  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      for (int i = 0; i < FIFO_D; i++) begin
        fifoMem_r[i] <= {DATA_W{1'b0}};
      end
      fifoLast_r <= {FIFO_D{1'b0}};
      wrPtr_r    <= {PTR_W{1'b0}};
      rdPtr_r    <= {PTR_W{1'b0}};
      fifoCnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifoMem_r[wrPtr_r]  <= bus.bank_data;
        fifoLast_r[wrPtr_r] <= pushLast_s;
        wrPtr_r             <= nextPtr(wrPtr_r);
      end
      if (pop_s) begin
        rdPtr_r <= nextPtr(rdPtr_r);
      end
      if (push_s && !pop_s) begin
        fifoCnt_r <= fifoCnt_r + CNT_W'(1);
      end else if (!push_s && pop_s) begin
        fifoCnt_r <= fifoCnt_r - CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = reqReady_r;
  assign bus.busy      = busy_r;
  assign bus.bank_cs   = issue_s;
  assign bus.bank_addr = addrQ_r;
  assign bus.out_valid = fifoNotEmpty_s;
  assign bus.out_data  = fifoMem_r[rdPtr_r];
  assign bus.out_last  = fifoLast_r[rdPtr_r] && fifoNotEmpty_s;

  // Credit invariant: no line may land in a full FIFO, outstanding reads fit the FIFO
  assert property (@(posedge vsi_clk) disable iff (vsi_reset)
    !(push_s && !pop_s && (fifoCnt_r == CNT_W'(FIFO_D))));
  assert property (@(posedge vsi_clk) disable iff (vsi_reset)
    ((fifoCnt_r + inFlight_s) <= CNT_W'(FIFO_D)));
endmodule
